icache: RTL
===========

Name: icache

Overview:
Direct-mapped, read-only instruction cache. It sits between the program counter and main memory. It takes the fetch address the PC drives each cycle and returns the instruction word one cycle later on a hit. On a miss it asserts o_busy in the same cycle, so the PC's inst-busy stall logic can capture the missed address, and then refills the whole line from memory with a burst handshake.

Parameters:
NUM_LINES, 32, number of lines; power of 2, >=2.
LINE_WORDS, 4, 32-bit words per line; power of 2, >=2.
Derived widths:
- OFF = log2(LINE_WORDS)+2
- IDX = log2(NUM_LINES)
- TAG = 32-OFF-IDX

Ports:
i_clk  in  1  global clock
i_rst  in  1  synchronous active-high reset
i_req_ren  in  1  fetch request valid this cycle
i_req_addr  in  32  fetch byte address; bits [1:0] ignored
o_res_rdata  out  32  instruction word, registered
o_busy  out  1  miss/refill in progress; PC must hold
i_inv  in  1  invalidate all lines (fence.i)
o_mem_ren  out  1  line burst request to memory
o_mem_addr  out  32  line base address, low OFF bits zero
i_mem_ready  in  1  memory accepts burst request
i_mem_valid  in  1  one refill beat on i_mem_rdata
i_mem_rdata  in  32  refill data, ascending word order from line base

Behaviour:
Interface
- Single clock i_clk; reset i_rst is synchronous and active-high.

Storage and address split
- Arrays: valid[NUM_LINES], tag[NUM_LINES][TAG], data[NUM_LINES*LINE_WORDS][32].
- Address fields: offset = addr[OFF-1:2], index = addr[OFF+IDX-1:OFF], tag = addr[31:OFF+IDX].

Reset
- valid all cleared.
- o_res_rdata=0, o_mem_ren=0, o_mem_addr=0.
- State IDLE, beat counter=0, inv_pend=0.
- o_busy=0 while i_rst is high.

Hit/miss
- hit = valid[index] & (tag[index]==tag).

FSM states: IDLE, MEMREQ, FILL.

IDLE
- i_req_ren & hit: o_res_rdata <= data[index,offset]; visible next cycle (1-cycle latency); o_busy=0.
- i_req_ren & !hit: o_busy=1 combinationally in the same cycle. Latch miss address into maddr. Next state MEMREQ.
- !i_req_ren: o_res_rdata holds its value.
- i_mem_valid and i_mem_ready are ignored.

MEMREQ
- o_mem_ren=1; o_mem_addr = {maddr[31:OFF], OFF'b0}. Both held stable until i_mem_ready.
- On i_mem_ready: o_mem_ren drops next cycle; counter=0; next state FILL.
- o_busy=1.

FILL
- o_busy=1.
- Each i_mem_valid: data[maddr index, counter] <= i_mem_rdata; counter++.
- The beat where counter == maddr offset is also captured into o_res_rdata.
- On the beat with counter == LINE_WORDS-1:
  - tag[index] <= maddr tag; valid[index] <= 1.
  - Next state IDLE.
  - o_busy is low the following cycle, with o_res_rdata holding the missed word.
- A request arriving in that first IDLE cycle is looked up against the updated arrays.

General rules
- i_req_addr and i_req_ren are ignored outside IDLE; maddr is used.
- Counter width log2(LINE_WORDS); it does not wrap within a fill.

Invalidate
- i_inv in IDLE: all valid bits clear at the clock edge. A lookup in the same cycle uses the pre-clear arrays.
- i_inv in MEMREQ/FILL sets inv_pend. When the fill completes, all valid bits clear, including the new line; o_res_rdata still delivers the missed word. inv_pend then clears.

Reset mid-operation
- Abort the fill; o_mem_ren=0 the next cycle; state IDLE; all lines invalid.
- Straggling i_mem_valid beats are ignored.

Simultaneous events
- i_mem_ready asserting together with i_mem_valid in the same MEMREQ cycle is a protocol error; memory returns its first beat no earlier than the cycle after ready.

Test Plan:
1. Cold miss:
   - Stimulus: req 0x00000000; mem_ready after 2 cycles; beats 0x11,0x22,0x33,0x44.
   - Required: busy=1 in the request cycle; mem_addr=0x00000000; busy=0 the cycle after the 4th beat; rdata=0x11.
   - Then req 0x00000004: rdata=0x22 next cycle, busy stays 0.
2. Critical word:
   - Stimulus: miss at 0x0000100C; beats A0..A3.
   - Required: mem_addr=0x00001000; rdata=A3 once busy falls; follow-up hits at 0x1000/0x1008 return A0/A2.
3. Conflict (defaults):
   - Stimulus: fill 0x00000000, then fill 0x00000200.
   - Required: 0x00000000 misses again (busy=1); 0x00000204 hits.
4. Invalidate during fill:
   - Stimulus: assert i_inv for one cycle during FILL.
   - Required: missed word still delivered; re-request of the same address misses.
5. Reset mid-fill:
   - Stimulus: assert i_rst after 2 of 4 beats.
   - Required: busy=0 and mem_ren=0 next cycle; remaining beats ignored; req 0x0 then misses with mem_addr=0x0.
6. Memory backpressure:
   - Stimulus: i_mem_ready low for 5 cycles.
   - Required: mem_ren=1 and mem_addr stable throughout; busy=1; i_req_addr changes ignored; the original line is refilled.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
// Looks up the fetch address in one cycle. On a miss it stalls the PC
// combinationally and refills the whole line through a request/beat handshake.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_req_ren/addr     fetch request and byte address
//   o_res_rdata        registered instruction word (1-cycle hit latency)
//   o_busy             combinational stall: miss or refill in progress
//   i_inv              invalidate all lines (fence.i)
//   o_mem_ren/addr     registered line burst request and line base address
//   i_mem_ready        memory accepts the burst request
//   i_mem_valid/rdata  refill beats in ascending word order
module icache #(
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_ren,
  input  logic [31:0] i_req_addr,
  output logic [31:0] o_res_rdata,
  output logic        o_busy,
  input  logic        i_inv,
  output logic        o_mem_ren,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);
  localparam int unsigned OFF  = $clog2(LINE_WORDS) + 2;
  localparam int unsigned IDX  = $clog2(NUM_LINES);
  localparam int unsigned TAG  = 32 - OFF - IDX;
  localparam int unsigned WOFF = OFF - 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MEMREQ = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     maddr_q, maddr_d;
  logic [WOFF-1:0] cnt_q, cnt_d;
  logic            inv_pend_q, inv_pend_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mem_ren_q, mem_ren_d;
  logic [31:0]     mem_addr_q, mem_addr_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG-1:0]       tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  logic inv_all_c, fill_we_c, fill_done_c, busy_c;

  // Address fields of the live request and of the latched miss address
  logic [WOFF-1:0] req_off, m_off;
  logic [IDX-1:0]  req_idx, m_idx;
  logic [TAG-1:0]  req_tag, m_tag;
  logic            hit;

  assign req_off = i_req_addr[OFF-1:2];
  assign req_idx = i_req_addr[OFF+IDX-1:OFF];
  assign req_tag = i_req_addr[31:OFF+IDX];
  assign m_off   = maddr_q[OFF-1:2];
  assign m_idx   = maddr_q[OFF+IDX-1:OFF];
  assign m_tag   = maddr_q[31:OFF+IDX];
  assign hit     = valid_q[req_idx] & (tag_q[req_idx] == req_tag);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr[1:0], maddr_q[1:0]};

  // Next-state, array-write strobes and the combinational stall
  always_comb begin
    state_d     = state_q;
    maddr_d     = maddr_q;
    cnt_d       = cnt_q;
    inv_pend_d  = inv_pend_q;
    rdata_d     = rdata_q;
    mem_ren_d   = mem_ren_q;
    mem_addr_d  = mem_addr_q;
    inv_all_c   = 1'b0;
    fill_we_c   = 1'b0;
    fill_done_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Lookup sees the pre-invalidate arrays; the clear lands at the edge
        inv_all_c = i_inv;
        if (i_req_ren) begin
          if (hit) begin
            rdata_d = data_q[{req_idx, req_off}];
          end else begin
            busy_c     = 1'b1;
            maddr_d    = i_req_addr;
            mem_ren_d  = 1'b1;
            mem_addr_d = {i_req_addr[31:OFF], {OFF{1'b0}}};
            state_d    = S_MEMREQ;
          end
        end
      end
      S_MEMREQ: begin
        busy_c = 1'b1;
        if (i_inv) inv_pend_d = 1'b1;
        if (i_mem_ready) begin
          mem_ren_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        busy_c = 1'b1;
        if (i_inv) inv_pend_d = 1'b1;
        if (i_mem_valid) begin
          fill_we_c = 1'b1;
          cnt_d     = cnt_q + WOFF'(1);
          // Critical word goes straight to the output register
          if (cnt_q == m_off) rdata_d = i_mem_rdata;
          if (cnt_q == WOFF'(LINE_WORDS - 1)) begin
            fill_done_c = 1'b1;
            // A pending fence.i also wipes the line just filled
            inv_all_c   = inv_pend_q | i_inv;
            inv_pend_d  = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (i_rst) busy_c = 1'b0;
  end

  assign o_busy      = busy_c;
  assign o_res_rdata = rdata_q;
  assign o_mem_ren   = mem_ren_q;
  assign o_mem_addr  = mem_addr_q;

  // Control and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      maddr_q    <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      rdata_q    <= '0;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      maddr_q    <= maddr_d;
      cnt_q      <= cnt_d;
      inv_pend_q <= inv_pend_d;
      rdata_q    <= rdata_d;
      mem_ren_q  <= mem_ren_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Valid bits: invalidate wins over the line being marked valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
    end else if (inv_all_c) begin
      valid_q <= '0;
    end else if (fill_done_c) begin
      valid_q[m_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; no reset, qualified by the valid bits
  always_ff @(posedge i_clk) begin
    if (!i_rst && fill_done_c) tag_q[m_idx] <= m_tag;
    if (!i_rst && fill_we_c) data_q[{m_idx, cnt_q}] <= i_mem_rdata;
  end
endmodule
